// File: rtl/pixel_frame_loader.sv
// Binarizes a raster stream of grayscale pixels into a flattened frame vector and
// holds each completed frame until acknowledged. Optional macro: LAST_CHECK_EN (pix_last framing check).
module pixel_frame_loader #(
    parameter int PIXELS = 784,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [PIXELS-1:0] frame_out,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic [9:0]        pix_idx,
    output logic [CNT_W-1:0]  frames_done
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [9:0]       LAST_IDX  = 10'(PIXELS - 1);
    localparam logic [PIX_W-1:0] THRESH_V  = PIX_W'(THRESH);

    state_t            state_reg, state_next;
    logic [9:0]        pix_idx_reg, pix_idx_next;
    logic [CNT_W-1:0]  frames_done_reg, frames_done_next;
    logic [PIXELS-1:0] frame_reg, frame_next;

    logic xfer;
    logic is_last_idx;
    logic framing_bad;
    logic pix_bit;

    assign xfer        = pix_valid && (state_reg == FILL);
    assign is_last_idx = (pix_idx_reg == LAST_IDX);
    assign pix_bit     = (pix_data >= THRESH_V);

`ifdef LAST_CHECK_EN
    logic frame_err_reg;

    // pix_last must coincide exactly with the final raster position
    assign framing_bad = xfer && (pix_last != is_last_idx);

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= framing_bad;
        end
    end

    assign frame_err = frame_err_reg;
`else
    logic unused_pix_last;

    assign unused_pix_last = pix_last;
    assign framing_bad     = 1'b0;
    assign frame_err       = 1'b0;
`endif

    // Per-bit write decode: only the bit addressed by pix_idx takes the new pixel
    generate
        for (genvar gi = 0; gi < PIXELS; gi++) begin : g_bit
            assign frame_next[gi] = (xfer && (pix_idx_reg == 10'(gi))) ? pix_bit : frame_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        pix_idx_next     = pix_idx_reg;
        frames_done_next = frames_done_reg;
        case (state_reg)
            FILL: begin
                if (xfer) begin
                    if (framing_bad || is_last_idx) begin
                        pix_idx_next = '0;
                    end else begin
                        pix_idx_next = pix_idx_reg + 10'd1;
                    end
                    if (is_last_idx && !framing_bad) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_next       = FILL;
                    frames_done_next = frames_done_reg + 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= FILL;
            pix_idx_reg     <= '0;
            frames_done_reg <= '0;
            frame_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            pix_idx_reg     <= pix_idx_next;
            frames_done_reg <= frames_done_next;
            frame_reg       <= frame_next;
        end
    end

    assign pix_ready   = (state_reg == FILL);
    assign frame_valid = (state_reg == HOLD);
    assign frame_out   = frame_reg;
    assign pix_idx     = pix_idx_reg;
    assign frames_done = frames_done_reg;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed self-checking bench for pixel_frame_loader; a second small instance
// (4 pixels, 2-bit counter) exercises the frames_done wrap cheaply.
module tb_pixel_frame_loader;

    localparam int NPIX = 784;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      pix_data = '0;
    logic            pix_valid = 1'b0;
    logic            pix_last = 1'b0;
    logic            pix_ready;
    logic [NPIX-1:0] frame_out;
    logic            frame_valid;
    logic            frame_ack = 1'b0;
    logic            frame_err;
    logic [9:0]      pix_idx;
    logic [15:0]     frames_done;

    logic [7:0]      s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [3:0]      s_frame;
    logic            s_fvalid;
    logic            s_ack = 1'b0;
    logic            s_err;
    logic [9:0]      s_idx;
    logic [1:0]      s_done;

    int checks = 0;
    int errors = 0;

    pixel_frame_loader dut (
        .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_ready(pix_ready), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err),
        .pix_idx(pix_idx), .frames_done(frames_done)
    );

    pixel_frame_loader #(.PIXELS(4), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .pix_data(s_data), .pix_valid(s_valid),
        .pix_last(s_last), .pix_ready(s_ready), .frame_out(s_frame),
        .frame_valid(s_fvalid), .frame_ack(s_ack), .frame_err(s_err),
        .pix_idx(s_idx), .frames_done(s_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic       exp_bit;
    } vec_t;

    vec_t            tbl[8];
    logic [7:0]      pix_mem[NPIX];
    logic [NPIX-1:0] exp_frame;
    logic [NPIX-1:0] held_frame;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h ok", name, act);
        end
    endtask

    task automatic check_frame(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
        int ndiff = 0;
        int first = -1;
        checks++;
        for (int i = 0; i < NPIX; i++) begin
            if (act[i] !== exp[i]) begin
                ndiff++;
                if (first < 0) first = i;
            end
        end
        if (ndiff != 0) begin
            errors++;
            $display("FAIL %s: %0d bits differ, first at %0d got %b expected %b",
                     name, ndiff, first, act[first], exp[first]);
        end else begin
            $display("check %s: frame ok", name);
        end
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic last);
        int n = 0;
        pix_data  = d;
        pix_last  = last;
        pix_valid = 1'b1;
        while (!pix_ready && n < 50) begin
            tick();
            n++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL pix_ready_timeout: got 0 expected 1");
        end
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    // Sends pix_mem as one frame; checks frame_valid stays low until the final transfer.
    task automatic send_frame(input string name, input int max_gap);
        for (int k = 0; k < NPIX; k++) begin
            if (k == NPIX - 1) check({name, "_valid_before_last"}, 32'(frame_valid), 32'd0);
            for (int g = $urandom_range(max_gap, 0); g > 0; g--) tick();
            send_pixel(pix_mem[k], k == NPIX - 1);
        end
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'd127, 1'b0};
        tbl[1] = '{8'd128, 1'b1};
        tbl[2] = '{8'd255, 1'b1};
        tbl[3] = '{8'd0,   1'b0};
        tbl[4] = '{8'd129, 1'b1};
        tbl[5] = '{8'd1,   1'b0};
        tbl[6] = '{8'd200, 1'b1};
        tbl[7] = '{8'd100, 1'b0};

        // reset, then mid-stream reset discards partial frame
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_ready", 32'(pix_ready), 32'd1);
        check("rst_valid", 32'(frame_valid), 32'd0);
        for (int k = 0; k < 5; k++) send_pixel(8'd200, 1'b0);
        check("idx_after_5", 32'(pix_idx), 32'd5);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check("midrst_idx", 32'(pix_idx), 32'd0);
        check("midrst_ready", 32'(pix_ready), 32'd1);
        check("midrst_valid", 32'(frame_valid), 32'd0);
        check("midrst_done", 32'(frames_done), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);

        // alternating 200/50 frame, back-to-back
        for (int k = 0; k < NPIX; k++) pix_mem[k] = (k % 2 == 0) ? 8'd200 : 8'd50;
        send_frame("alt", 0);
        check("alt_valid", 32'(frame_valid), 32'd1);
        check("alt_ready", 32'(pix_ready), 32'd0);
        check("alt_idx", 32'(pix_idx), 32'd0);
        check_frame("alt_frame", frame_out, {392{2'b01}});

        // hold with pix_valid asserted: nothing accepted
        held_frame = {392{2'b01}};
        pix_valid  = 1'b1;
        pix_data   = 8'd0;
        for (int c = 0; c < 10; c++) tick();
        pix_valid = 1'b0;
        check("hold_valid", 32'(frame_valid), 32'd1);
        check("hold_idx", 32'(pix_idx), 32'd0);
        check("hold_ready", 32'(pix_ready), 32'd0);
        check_frame("hold_frame", frame_out, held_frame);
        ack_frame();
        check("ack_valid", 32'(frame_valid), 32'd0);
        check("ack_done", 32'(frames_done), 32'd1);
        check("ack_ready", 32'(pix_ready), 32'd1);
        // stray ack while idle must be ignored
        ack_frame();
        check("stray_ack_done", 32'(frames_done), 32'd1);

        // threshold table leads the frame, rest zero
        for (int k = 0; k < NPIX; k++) pix_mem[k] = 8'd0;
        for (int i = 0; i < 8; i++) pix_mem[i] = tbl[i].pix;
        send_frame("thr", 0);
        check("thr_valid", 32'(frame_valid), 32'd1);
        check("thr_low4", 32'(frame_out[3:0]), 32'b0110);
        for (int i = 0; i < 8; i++)
            check($sformatf("thr_bit%0d_pix%0d", i, tbl[i].pix), 32'(frame_out[i]), 32'(tbl[i].exp_bit));
        check("thr_upper_zero", 32'(frame_out[NPIX-1:8] == '0), 32'd1);
        ack_frame();
        check("thr_done", 32'(frames_done), 32'd2);

        // random-gap frame; pattern: every third pixel bright
        exp_frame = '0;
        for (int k = 0; k < NPIX; k++) begin
            pix_mem[k]   = (k % 3 == 0) ? 8'd255 : 8'd10;
            exp_frame[k] = (k % 3 == 0);
        end
        send_frame("gap", 2);
        check("gap_valid", 32'(frame_valid), 32'd1);
        check_frame("gap_frame", frame_out, exp_frame);
        ack_frame();
        check("gap_done", 32'(frames_done), 32'd3);

`ifdef LAST_CHECK_EN
        // early pix_last aborts the frame
        for (int k = 0; k < 500; k++) send_pixel(8'd200, 1'b0);
        send_pixel(8'd200, 1'b1);
        check("abort_err", 32'(frame_err), 32'd1);
        check("abort_idx", 32'(pix_idx), 32'd0);
        check("abort_valid", 32'(frame_valid), 32'd0);
        tick();
        check("abort_err_pulse", 32'(frame_err), 32'd0);
        // missing pix_last at final position drops the frame
        for (int k = 0; k < NPIX; k++) send_pixel(8'd200, 1'b0);
        check("drop_err", 32'(frame_err), 32'd1);
        check("drop_valid", 32'(frame_valid), 32'd0);
        check("drop_idx", 32'(pix_idx), 32'd0);
        for (int k = 0; k < NPIX; k++) pix_mem[k] = 8'd200;
        send_frame("clean", 0);
        check("clean_valid", 32'(frame_valid), 32'd1);
        check("clean_err", 32'(frame_err), 32'd0);
        check_frame("clean_frame", frame_out, {NPIX{1'b1}});
        ack_frame();
        check("clean_done", 32'(frames_done), 32'd4);
`endif

        // small instance: 2-bit frames_done wraps after 4 acks
        for (int f = 1; f <= 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                s_data  = (k % 2 == 0) ? 8'd200 : 8'd0;
                s_last  = (k == 3);
                s_valid = 1'b1;
                tick();
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            check($sformatf("small_valid_f%0d", f), 32'(s_fvalid), 32'd1);
            check($sformatf("small_frame_f%0d", f), 32'(s_frame), 32'b0101);
            s_ack = 1'b1;
            tick();
            s_ack = 1'b0;
            check($sformatf("small_done_f%0d", f), 32'(s_done), 32'(f % 4));
        end

        // reset while holding a frame
        for (int k = 0; k < NPIX; k++) pix_mem[k] = 8'd255;
        send_frame("pre_rst", 0);
        check("pre_rst_valid", 32'(frame_valid), 32'd1);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check("holdrst_valid", 32'(frame_valid), 32'd0);
        check("holdrst_done", 32'(frames_done), 32'd0);
        check("holdrst_ready", 32'(pix_ready), 32'd1);
        check_frame("holdrst_frame", frame_out, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
